fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 138 +++++++++++++
 tb/tb_fetch_queue.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Two-wide instruction fetch queue between the I-cache and decode.
// Circular buffer: two lanes in, two lanes out, flush on redirect.
module fetch_queue #(
  parameter int instrWidth = 32,
  parameter int depth      = 8
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  flush,
  input  logic                  enqValid1,
  input  logic                  enqValid2,
  input  logic [instrWidth-1:0] pcF1,
  input  logic [instrWidth-1:0] pcF2,
  input  logic [instrWidth-1:0] instrF1,
  input  logic [instrWidth-1:0] instrF2,
  output logic                  enqReady,
  output logic                  deqValid1,
  output logic                  deqValid2,
  output logic [instrWidth-1:0] deqPc1,
  output logic [instrWidth-1:0] deqPc2,
  output logic [instrWidth-1:0] deqInstr1,
  output logic [instrWidth-1:0] deqInstr2,
  input  logic                  deqTake1,
  input  logic                  deqTake2,
  output logic [$clog2(depth):0] count
);

  localparam int ptrW = $clog2(depth);
  localparam int cntW = ptrW + 1;

  localparam logic [cntW-1:0] enqLimit =
    cntW'(depth - 2);

  typedef struct packed {
    logic [instrWidth-1:0] pc;
    logic [instrWidth-1:0] instr;
  } entryT;

  entryT mem [depth];

  logic [ptrW-1:0] head;
  logic [ptrW-1:0] tail;
  logic [ptrW-1:0] headNext;
  logic [ptrW-1:0] tailNext;
  logic [ptrW-1:0] head1;
  logic [ptrW-1:0] tail1;
  logic [cntW-1:0] countNext;

  logic            enqOne;
  logic            enqTwo;
  logic            takeOne;
  logic            takeTwo;
  logic [1:0]      numEnq;
  logic [1:0]      numTake;

  assign head1 = head + ptrW'(1);
  assign tail1 = tail + ptrW'(1);

  // Readiness looks only at registered occupancy.
  assign enqReady  = (count <= enqLimit);
  assign deqValid1 = (count >= cntW'(1));
  assign deqValid2 = (count >= cntW'(2));

  assign enqOne = enqReady && enqValid1 && !enqValid2;
  assign enqTwo = enqReady && enqValid1 && enqValid2;

  assign takeTwo = deqTake1 && deqValid1 &&
                   deqTake2 && deqValid2;
  assign takeOne = deqTake1 && deqValid1 && !takeTwo;

  always_comb begin
    numEnq = 2'd0;
    unique case (1'b1)
      enqTwo:  numEnq = 2'd2;
      enqOne:  numEnq = 2'd1;
      default: numEnq = 2'd0;
    endcase
  end

  always_comb begin
    numTake = 2'd0;
    unique case (1'b1)
      takeTwo: numTake = 2'd2;
      takeOne: numTake = 2'd1;
      default: numTake = 2'd0;
    endcase
  end

  always_comb begin
    headNext  = head + ptrW'(numTake);
    tailNext  = tail + ptrW'(numEnq);
    countNext = count + cntW'(numEnq)
                      - cntW'(numTake);
    if (flush) begin
      headNext  = '0;
      tailNext  = '0;
      countNext = '0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= headNext;
      tail  <= tailNext;
      count <= countNext;
    end
  end

  // Storage is never reset; valids mask stale entries.
  always_ff @(posedge clk) begin
    if (!flush && (enqOne || enqTwo)) begin
      mem[tail] <= '{pc: pcF1, instr: instrF1};
    end
    if (!flush && enqTwo) begin
      mem[tail1] <= '{pc: pcF2, instr: instrF2};
    end
  end

  always_comb begin
    deqPc1    = '0;
    deqInstr1 = '0;
    deqPc2    = '0;
    deqInstr2 = '0;
    if (deqValid1) begin
      deqPc1    = mem[head].pc;
      deqInstr1 = mem[head].instr;
    end
    if (deqValid2) begin
      deqPc2    = mem[head1].pc;
      deqInstr2 = mem[head1].instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed steps plus a random tail,
// checked against a queue-based scoreboard of expected entries.
module tb_fetch_queue;

  localparam int W = 32;
  localparam int D = 8;

  logic         clk;
  logic         rstN;
  logic         flush;
  logic         enqValid1;
  logic         enqValid2;
  logic [W-1:0] pcF1;
  logic [W-1:0] pcF2;
  logic [W-1:0] instrF1;
  logic [W-1:0] instrF2;
  logic         enqReady;
  logic         deqValid1;
  logic         deqValid2;
  logic [W-1:0] deqPc1;
  logic [W-1:0] deqPc2;
  logic [W-1:0] deqInstr1;
  logic [W-1:0] deqInstr2;
  logic         deqTake1;
  logic         deqTake2;
  logic [3:0]   count;

  typedef struct {
    logic [W-1:0] pc;
    logic [W-1:0] instr;
  } entT;

  entT sb[$];
  int  errors = 0;
  int  checks = 0;

  fetch_queue #(.instrWidth(W), .depth(D)) dut (
    .clk(clk), .rstN(rstN), .flush(flush),
    .enqValid1(enqValid1), .enqValid2(enqValid2),
    .pcF1(pcF1), .pcF2(pcF2),
    .instrF1(instrF1), .instrF2(instrF2),
    .enqReady(enqReady),
    .deqValid1(deqValid1), .deqValid2(deqValid2),
    .deqPc1(deqPc1), .deqPc2(deqPc2),
    .deqInstr1(deqInstr1), .deqInstr2(deqInstr2),
    .deqTake1(deqTake1), .deqTake2(deqTake2),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    int n;
    logic [W-1:0] p1, i1, p2, i2;
    n  = sb.size();
    p1 = '0; i1 = '0; p2 = '0; i2 = '0;
    if (n >= 1) begin p1 = sb[0].pc; i1 = sb[0].instr; end
    if (n >= 2) begin p2 = sb[1].pc; i2 = sb[1].instr; end
    chk({tag, ".count"}, W'(count), W'(n));
    chk({tag, ".enqReady"}, W'(enqReady),
        W'(n <= D - 2));
    chk({tag, ".deqValid1"}, W'(deqValid1), W'(n >= 1));
    chk({tag, ".deqValid2"}, W'(deqValid2), W'(n >= 2));
    chk({tag, ".deqPc1"}, deqPc1, p1);
    chk({tag, ".deqInstr1"}, deqInstr1, i1);
    chk({tag, ".deqPc2"}, deqPc2, p2);
    chk({tag, ".deqInstr2"}, deqInstr2, i2);
  endtask

  task automatic drive(input logic e1, input logic e2,
                       input logic [W-1:0] p1,
                       input logic [W-1:0] i1,
                       input logic [W-1:0] p2,
                       input logic [W-1:0] i2,
                       input logic t1, input logic t2,
                       input logic fl);
    enqValid1 = e1; enqValid2 = e2;
    pcF1 = p1; instrF1 = i1;
    pcF2 = p2; instrF2 = i2;
    deqTake1 = t1; deqTake2 = t2;
    flush = fl;
  endtask

  // One clock edge; the scoreboard applies the same edge.
  task automatic cycle(input string tag);
    int  n;
    int  nt;
    bit  rdy;
    bit  fl, e1, e2, t1, t2;
    entT a, b;
    n  = sb.size();
    rdy = (n <= D - 2);
    fl = flush; e1 = enqValid1; e2 = enqValid2;
    t1 = deqTake1; t2 = deqTake2;
    a.pc = pcF1; a.instr = instrF1;
    b.pc = pcF2; b.instr = instrF2;
    @(posedge clk);
    #1;
    if (fl) begin
      sb.delete();
    end else begin
      nt = 0;
      if (t1 && n >= 1) nt = (t2 && n >= 2) ? 2 : 1;
      repeat (nt) void'(sb.pop_front());
      if (rdy && e1) begin
        sb.push_back(a);
        if (e2) sb.push_back(b);
      end
    end
    drive(0, 0, '0, '0, '0, '0, 0, 0, 0);
    checkAll(tag);
  endtask

  function automatic logic [W-1:0] ins(input int k);
    return W'(32'h1000_0000 + k * 32'h11);
  endfunction

  initial begin
    rstN = 1'b0;
    drive(0, 0, '0, '0, '0, '0, 0, 0, 0);
    #2;
    checkAll("reset");
    @(posedge clk); #1;
    checkAll("resetEdge");
    rstN = 1'b1;

    // First packet, visible one cycle later.
    drive(1, 1, 32'h0, 32'h11, 32'h4, 32'h22, 0, 0, 0);
    cycle("firstPkt");
    chk("firstInstr1", deqInstr1, 32'h11);
    chk("firstInstr2", deqInstr2, 32'h22);

    // Fill to full, then a packet that must be ignored.
    for (int k = 1; k < 4; k++) begin
      drive(1, 1, W'(8 * k), ins(2 * k),
            W'(8 * k + 4), ins(2 * k + 1), 0, 0, 0);
      cycle("fill");
    end
    chk("fullCount", W'(count), 32'd8);
    chk("fullReady", W'(enqReady), 32'd0);
    drive(1, 1, 32'hdead, 32'hdead, 32'hbeef,
          32'hbeef, 0, 0, 0);
    cycle("overflow");
    chk("overflowCount", W'(count), 32'd8);

    drive(0, 0, '0, '0, '0, '0, 1, 1, 0);
    cycle("take2");

    // Steady state at 6 while pointers wrap past 7->0.
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, W'(32'h100 + 8 * k), ins(20 + 2 * k),
            W'(32'h104 + 8 * k), ins(21 + 2 * k),
            1, 1, 0);
      cycle("steady6");
      chk("steadyCount", W'(count), 32'd6);
    end

    drive(0, 0, '0, '0, '0, '0, 1, 0, 0);
    cycle("take1");
    drive(0, 0, '0, '0, '0, '0, 0, 1, 0);
    cycle("take2only");
    drive(0, 1, 32'h77, 32'h77, 32'h78, 32'h78, 0, 0, 0);
    cycle("enq2only");
    drive(0, 0, '0, '0, '0, '0, 1, 1, 0);
    cycle("drain2a");
    drive(0, 0, '0, '0, '0, '0, 1, 1, 0);
    cycle("drain2b");
    chk("oneLeft", W'(count), 32'd1);
    drive(0, 0, '0, '0, '0, '0, 1, 1, 0);
    cycle("lastTake");
    chk("emptyCount", W'(count), 32'd0);
    chk("emptyData", deqInstr1, 32'd0);

    // Single-lane enqueues then flush at count 5.
    drive(1, 0, 32'h200, ins(40), 32'h0, 32'h0, 0, 0, 0);
    cycle("lane1only");
    for (int k = 0; k < 2; k++) begin
      drive(1, 1, W'(32'h300 + 8 * k), ins(50 + 2 * k),
            W'(32'h304 + 8 * k), ins(51 + 2 * k),
            0, 0, 0);
      cycle("to5");
    end
    chk("five", W'(count), 32'd5);
    drive(1, 1, 32'h400, ins(60), 32'h404, ins(61),
          1, 1, 1);
    cycle("flush");
    chk("flushCount", W'(count), 32'd0);
    chk("flushReady", W'(enqReady), 32'd1);

    // Asynchronous reset between edges at count 4.
    for (int k = 0; k < 2; k++) begin
      drive(1, 1, W'(32'h500 + 8 * k), ins(70 + 2 * k),
            W'(32'h504 + 8 * k), ins(71 + 2 * k),
            0, 0, 0);
      cycle("to4");
    end
    chk("four", W'(count), 32'd4);
    #1;
    rstN = 1'b0;
    sb.delete();
    #1;
    chk("asyncCount", W'(count), 32'd0);
    chk("asyncValid", W'(deqValid1), 32'd0);
    checkAll("asyncRst");
    #1;
    rstN = 1'b1;
    drive(1, 1, 32'h600, ins(80), 32'h604, ins(81),
          1, 1, 0);
    cycle("postRst");

    // Random traffic against the scoreboard.
    for (int k = 0; k < 300; k++) begin
      drive(1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            $urandom, $urandom, $urandom, $urandom,
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            $urandom_range(0, 19) == 0);
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
